// File: rtl/direction_queue_ctrl_if.sv
// Shared heading type plus the bundle of per-channel mouse/tick inputs and
// direction/queue status outputs that connect the controller to the game.
package game_pkg;
  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    UP    = 3'd4
  } directions;
endpackage

interface direction_queue_ctrl_if #(
  parameter int NUM_CH      = 2,
  parameter int QUEUE_DEPTH = 2
);
  localparam int LW = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_CH-1:0]   mouse_right;
  logic [NUM_CH-1:0]   mouse_left;
  logic                move_tick;
  logic                clear;
  game_pkg::directions direction   [NUM_CH];
  logic [NUM_CH-1:0]   turn_applied;
  logic [LW-1:0]       queue_level [NUM_CH];
  logic [NUM_CH-1:0]   overflow;

  modport master (
    output mouse_right, mouse_left, move_tick, clear,
    input  direction, turn_applied, queue_level, overflow
  );

  modport slave (
    input  mouse_right, mouse_left, move_tick, clear,
    output direction, turn_applied, queue_level, overflow
  );
endinterface

// File: rtl/direction_queue_ctrl.sv
// Per-snake turn queue: button rising edges become R/L tokens held in a small
// circular FIFO; one token is popped and applied to the heading per move_tick.
module direction_queue_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int QUEUE_DEPTH = 2,
  parameter int TURN_MODE   = 0
) (
  input logic                   clk,
  input logic                   rst,
  direction_queue_ctrl_if.slave bus
);
  import game_pkg::*;

  localparam int LW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  directions              direction_q [NUM_CH];
  directions              direction_d [NUM_CH];
  logic [LW-1:0]          level_q     [NUM_CH];
  logic [LW-1:0]          level_d     [NUM_CH];
  logic [PW-1:0]          rd_q        [NUM_CH];
  logic [PW-1:0]          rd_d        [NUM_CH];
  logic [PW-1:0]          wr_q        [NUM_CH];
  logic [PW-1:0]          wr_d        [NUM_CH];
  // One bit per slot: 1 = R token, 0 = L token.
  logic [QUEUE_DEPTH-1:0] mem_q       [NUM_CH];
  logic [QUEUE_DEPTH-1:0] mem_d       [NUM_CH];
  logic [NUM_CH-1:0]      right_q, right_d;
  logic [NUM_CH-1:0]      left_q, left_d;
  logic [NUM_CH-1:0]      overflow_q, overflow_d;
  logic [NUM_CH-1:0]      turn_applied_q, turn_applied_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Heading after applying one token; a corrupted heading falls back to WAIT.
  function automatic directions next_dir(input directions cur, input logic tok_r);
    directions nd;
    nd = WAIT;
    if (TURN_MODE == 0) begin
      case (cur)
        WAIT, DOWN, UP: nd = tok_r ? RIGHT : LEFT;
        RIGHT:          nd = tok_r ? DOWN  : UP;
        LEFT:           nd = tok_r ? UP    : DOWN;
        default:        nd = WAIT;
      endcase
    end else begin
      case (cur)
        WAIT:    nd = tok_r ? RIGHT : LEFT;
        RIGHT:   nd = tok_r ? DOWN  : UP;
        DOWN:    nd = tok_r ? LEFT  : RIGHT;
        LEFT:    nd = tok_r ? UP    : DOWN;
        UP:      nd = tok_r ? RIGHT : LEFT;
        default: nd = WAIT;
      endcase
    end
    return nd;
  endfunction

  // Edge detect, FIFO push/pop, heading update and flush for every channel.
  always_comb begin
    logic press_r, press_l, pop, push_ok;
    press_r        = 1'b0;
    press_l        = 1'b0;
    pop            = 1'b0;
    push_ok        = 1'b0;
    right_d        = bus.mouse_right;
    left_d         = bus.mouse_left;
    overflow_d     = overflow_q;
    turn_applied_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      direction_d[c] = direction_q[c];
      level_d[c]     = level_q[c];
      rd_d[c]        = rd_q[c];
      wr_d[c]        = wr_q[c];
      mem_d[c]       = mem_q[c];

      press_r = bus.mouse_right[c] & ~right_q[c];
      press_l = bus.mouse_left[c]  & ~left_q[c];
      pop     = bus.move_tick && (level_q[c] != '0);
      // A pop in the same cycle frees the slot, so a full queue still accepts.
      push_ok = (press_r | press_l) && (pop || (level_q[c] != LW'(QUEUE_DEPTH)));

      if (pop) begin
        direction_d[c]    = next_dir(direction_q[c], mem_q[c][rd_q[c]]);
        turn_applied_d[c] = 1'b1;
        rd_d[c]           = ptr_inc(rd_q[c]);
      end

      if (push_ok) begin
        mem_d[c][wr_q[c]] = press_r;
        wr_d[c]           = ptr_inc(wr_q[c]);
      end else if (press_r | press_l) begin
        overflow_d[c] = 1'b1;
      end

      if (push_ok && !pop)      level_d[c] = level_q[c] + 1'b1;
      else if (!push_ok && pop) level_d[c] = level_q[c] - 1'b1;

      if (bus.clear) begin
        direction_d[c]    = WAIT;
        level_d[c]        = '0;
        rd_d[c]           = '0;
        wr_d[c]           = '0;
        right_d[c]        = 1'b0;
        left_d[c]         = 1'b0;
        overflow_d[c]     = 1'b0;
        turn_applied_d[c] = 1'b0;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        direction_q[c] <= WAIT;
        level_q[c]     <= '0;
        rd_q[c]        <= '0;
        wr_q[c]        <= '0;
      end
      right_q        <= '0;
      left_q         <= '0;
      overflow_q     <= '0;
      turn_applied_q <= '0;
    end else begin
      direction_q    <= direction_d;
      level_q        <= level_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      right_q        <= right_d;
      left_q         <= left_d;
      overflow_q     <= overflow_d;
      turn_applied_q <= turn_applied_d;
    end
  end

  // Token storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.direction[g]   = direction_q[g];
    assign bus.queue_level[g] = level_q[g];
  end
  assign bus.turn_applied = turn_applied_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_direction_queue_ctrl.sv
// Drives two controllers (depth 3 legacy mapping, depth 2 relative mapping)
// with identical stimulus and compares every output each cycle to a
// token-list reference model.
module tb_direction_queue_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mr  = '0;
  logic [1:0] ml  = '0;
  logic       tick = 1'b0;
  logic       clr  = 1'b0;

  int n_checks = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  direction_queue_ctrl_if #(.NUM_CH(2), .QUEUE_DEPTH(3)) bus_a ();
  direction_queue_ctrl_if #(.NUM_CH(2), .QUEUE_DEPTH(2)) bus_b ();

  assign bus_a.mouse_right = mr;
  assign bus_a.mouse_left  = ml;
  assign bus_a.move_tick   = tick;
  assign bus_a.clear       = clr;
  assign bus_b.mouse_right = mr;
  assign bus_b.mouse_left  = ml;
  assign bus_b.move_tick   = tick;
  assign bus_b.clear       = clr;

  direction_queue_ctrl #(.NUM_CH(2), .QUEUE_DEPTH(3), .TURN_MODE(0)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  direction_queue_ctrl #(.NUM_CH(2), .QUEUE_DEPTH(2), .TURN_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  // Reference model state, indexed [instance][channel]. Tokens are a list
  // kept in a shift vector: bit 0 is the oldest, cnt is the list length.
  int        depth_m [2] = '{3, 2};
  int        mode_m  [2] = '{0, 1};
  directions dir_m   [2][2];
  logic [7:0] tok_m  [2][2];
  int        cnt_m   [2][2];
  bit        ovf_m   [2][2];
  bit        ta_m    [2][2];
  bit        pr_m    [2][2];
  bit        pl_m    [2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic directions model_next(input int mode, input directions cur, input bit r);
    directions ring [4];
    int idx;
    ring = '{RIGHT, DOWN, LEFT, UP};
    if (mode == 0) begin
      if (cur == RIGHT) return r ? DOWN : UP;
      if (cur == LEFT)  return r ? UP : DOWN;
      return r ? RIGHT : LEFT;
    end
    if (cur == WAIT) return r ? RIGHT : LEFT;
    idx = 0;
    for (int k = 0; k < 4; k++) if (ring[k] == cur) idx = k;
    return ring[(idx + (r ? 1 : 3)) % 4];
  endfunction

  task automatic model_update();
    bit er, el, t;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst || clr) begin
          dir_m[i][c] = WAIT; tok_m[i][c] = '0; cnt_m[i][c] = 0;
          ovf_m[i][c] = 0; ta_m[i][c] = 0; pr_m[i][c] = 0; pl_m[i][c] = 0;
        end else begin
          er = mr[c] && !pr_m[i][c];
          el = ml[c] && !pl_m[i][c];
          pr_m[i][c] = mr[c];
          pl_m[i][c] = ml[c];
          ta_m[i][c] = 0;
          if (tick && cnt_m[i][c] > 0) begin
            t = tok_m[i][c][0];
            tok_m[i][c] = tok_m[i][c] >> 1;
            cnt_m[i][c]--;
            dir_m[i][c] = model_next(mode_m[i], dir_m[i][c], t);
            ta_m[i][c] = 1;
          end
          if (er || el) begin
            if (cnt_m[i][c] < depth_m[i]) begin
              tok_m[i][c][cnt_m[i][c]] = er;
              cnt_m[i][c]++;
            end else begin
              ovf_m[i][c] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("A.dir%0d", c),   bus_a.direction[c],    dir_m[0][c]);
      chk($sformatf("A.ta%0d", c),    bus_a.turn_applied[c], ta_m[0][c]);
      chk($sformatf("A.level%0d", c), bus_a.queue_level[c],  cnt_m[0][c]);
      chk($sformatf("A.ovf%0d", c),   bus_a.overflow[c],     ovf_m[0][c]);
      chk($sformatf("B.dir%0d", c),   bus_b.direction[c],    dir_m[1][c]);
      chk($sformatf("B.ta%0d", c),    bus_b.turn_applied[c], ta_m[1][c]);
      chk($sformatf("B.level%0d", c), bus_b.queue_level[c],  cnt_m[1][c]);
      chk($sformatf("B.ovf%0d", c),   bus_b.overflow[c],     ovf_m[1][c]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic pulse_r(input int c);
    mr[c] = 1'b1; step(); mr[c] = 1'b0; step();
  endtask

  task automatic pulse_l(input int c);
    ml[c] = 1'b1; step(); ml[c] = 1'b0; step();
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic do_clear();
    clr = 1'b1; step(); clr = 1'b0; step();
  endtask

  initial begin
    // Reset, then basic legacy mapping on channel 0.
    rst = 1'b1; step(); rst = 1'b0; step();
    pulse_r(0); do_tick();
    pulse_r(0); do_tick();
    pulse_l(0); do_tick();

    // Held button yields one token; simultaneous rise pushes R only.
    mr[0] = 1'b1; repeat (20) step(); mr[0] = 1'b0;
    do_tick(); do_tick();
    mr[0] = 1'b1; ml[0] = 1'b1; step(); mr[0] = 1'b0; ml[0] = 1'b0; step();
    do_tick();

    // Overflow and sticky flag, then flush.
    do_clear();
    pulse_r(0); pulse_l(0); pulse_r(0); pulse_l(0);
    do_tick(); do_tick(); step(); step();
    do_clear();

    // Full queue plus press plus tick; empty queue plus press plus tick.
    pulse_r(0); pulse_l(0); pulse_r(0);
    mr[0] = 1'b1; tick = 1'b1; step(); mr[0] = 1'b0; tick = 1'b0; step();
    do_clear();
    ml[0] = 1'b1; tick = 1'b1; step(); ml[0] = 1'b0; tick = 1'b0; step();
    do_tick();

    // Rotation runs: four R turns then four L turns.
    do_clear();
    pulse_r(0); do_tick();
    repeat (4) begin pulse_r(0); do_tick(); end
    repeat (4) begin pulse_l(0); do_tick(); end

    // Interleaved channels across pointer wrap, reset mid-sequence.
    do_clear();
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0) pulse_l(1); else pulse_r(0);
      if (k % 2 == 0) pulse_r(1); else pulse_l(0);
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    pulse_r(0); pulse_l(1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // Random traffic with occasional clear/reset.
    for (int n = 0; n < 1500; n++) begin
      mr   = 2'($urandom_range(0, 3));
      ml   = 2'($urandom_range(0, 3));
      tick = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 149) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    mr = '0; ml = '0; tick = 1'b0; clr = 1'b0; rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule

// File: doc/direction_queue_ctrl.md
Name: direction_queue_ctrl

Overview:
- Multi-channel successor to the single-player direction controller. One channel per snake.
- Each channel turns mouse button presses into turn tokens and buffers them in a per-channel FIFO.
- Tokens are applied to the channel's `directions` register only on the game `move_tick`, so quick double-clicks between moves are not lost.
- Sits between the mouse interface and the snake movement/draw logic, clocked in the game clock domain.

Parameters:
- NUM_CH, 2: number of independent channels (snakes). Legal range 1..4.
- QUEUE_DEPTH, 2: turn tokens buffered per channel. Legal range 1..8.
- TURN_MODE, 0: turn mapping.
  - 0 = LEGACY mapping.
  - 1 = RELATIVE rotate (clockwise/counter-clockwise).

Ports:
- clk  in  1  game clock
- rst  in  1  synchronous, active-high reset
- mouse_right  in  NUM_CH  per-channel right-button level
- mouse_left  in  NUM_CH  per-channel left-button level
- move_tick  in  1  one-cycle pulse, shared step strobe; tokens are applied on it
- clear  in  1  synchronous new-game flush of all channels
- direction  out  NUM_CH x directions  current heading per channel (game_pkg enum)
- turn_applied  out  NUM_CH  one-cycle pulse, aligned with the direction update
- queue_level  out  NUM_CH x $clog2(QUEUE_DEPTH+1)  tokens currently queued
- overflow  out  NUM_CH  sticky flag: a token was dropped because the queue was full

Behaviour:
- Reset (rst=1 at posedge):
  - direction=WAIT, queues empty, queue_level=0.
  - turn_applied=0, overflow=0, button history registers=0.
  - rst has priority over everything.
- clear=1 (rst=0): same effect as reset on all channels, including history and overflow. Any press or tick in that same cycle is ignored.
- Edge detect:
  - press_r = mouse_right & ~right_q; press_l likewise (right_q/left_q are the previous-cycle samples).
  - A held button produces exactly one token.
  - If both rise in the same cycle, only R is pushed (right priority).
- Token push:
  - A press pushes R or L at the FIFO tail.
  - If the queue is full and no pop occurs this cycle, the token is dropped and overflow[ch] is set.
  - overflow stays set until rst or clear.
- Token pop/apply:
  - On a cycle with move_tick=1 and a non-empty queue: pop the head and compute next_dir from direction and the token.
  - direction and turn_applied=1 are registered on that same edge, so both are visible in the following cycle.
  - move_tick with an empty queue: direction holds, turn_applied=0.
- Simultaneous push and pop:
  - The pop takes the existing head; the new token goes to the tail.
  - level is unchanged; no overflow even when the queue is full.
  - With an empty queue plus a press plus a tick in the same cycle: the token is queued (level becomes 1) and is applied on the next tick. There is no bypass.
- TURN_MODE=0 (LEGACY mapping):
  - WAIT: R→RIGHT, L→LEFT.
  - RIGHT: R→DOWN, L→UP.
  - DOWN: R→RIGHT, L→LEFT.
  - LEFT: R→UP, L→DOWN.
  - UP: R→RIGHT, L→LEFT.
- TURN_MODE=1 (RELATIVE mapping):
  - R rotates clockwise: RIGHT→DOWN→LEFT→UP→RIGHT.
  - L rotates counter-clockwise.
  - From WAIT: R→RIGHT, L→LEFT.
- Illegal enum value in the direction register: next_dir=WAIT on the next applied token. Otherwise hold.
- Channels are fully independent apart from the shared move_tick, clear and rst.
- FIFO implementation:
  - Circular buffer with rd/wr pointers wrapping at QUEUE_DEPTH (non-power-of-2 depths must wrap correctly), plus a level counter.
  - Full when level==QUEUE_DEPTH; empty when level==0.
- queue_level is the registered level counter.

Test Plan:
- Reset/clear, mapping, CH0, QUEUE_DEPTH=2, TURN_MODE=0: after rst, direction=WAIT, level=0. Pulse right 1 cycle, then tick → direction=RIGHT with turn_applied=1 in the same cycle. Press right then tick → DOWN. Then press left, tick → LEFT.
- Edge detect/priority: hold mouse_right high 20 cycles, then tick twice → one token only, direction=RIGHT, second tick leaves turn_applied=0. Raise both buttons on the same cycle → level=1 with an R token.
- Buffering/overflow, QUEUE_DEPTH=2: three presses R,L,R with no tick → level=2, overflow=1. Two ticks → WAIT→RIGHT→UP. overflow stays 1 until clear, then everything returns to reset values.
- Simultaneous events: queue full (level=2), press and tick in the same cycle → level stays 2, overflow=0, head applied. Empty queue plus press plus tick → no direction change, level=1; next tick applies it.
- RELATIVE mode, TURN_MODE=1: from RIGHT, four R tokens over four ticks → DOWN, LEFT, UP, RIGHT. Four L tokens return the reverse sequence.
- Multi-channel isolation, NUM_CH=2, QUEUE_DEPTH=3 (wrap check): interleave presses on CH0/CH1 for more than 6 push/pop cycles → each channel follows its own sequence, with pointer wrap correct. rst asserted mid-sequence → both channels WAIT and empty on the next cycle.
